// File: rtl/qu_uop_pkg.sv
// Shared micro-op definitions for the queue/issue stage.
package qu_uop_pkg;

    localparam int unsigned PHY_RF_ADDR_WIDTH = 6;
    localparam int unsigned UOP_WIDTH         = 82;

    typedef enum logic [1:0] {
        OptypeInt  = 2'd0,
        OptypeCont = 2'd1,
        OptypeMem  = 2'd2,
        OptypeFp   = 2'd3
    } optype_e;

    // 2+5+6+1+6+1+6+1+6+32+16 = 82 bits
    typedef struct packed {
        optype_e                        optype;
        logic [4:0]                     fu_op;
        logic [5:0]                     rob_idx;
        logic                           rd_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rd;
        logic                           rs1_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs1;
        logic                           rs2_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs2;
        logic [31:0]                    imm;
        logic [15:0]                    pc;
    } uop_t;

    typedef struct packed {
        uop_t uop;
        logic rs1_rdy;
        logic rs2_rdy;
        logic valid;
    } rs_entry_t;

    // Mark sources ready when the broadcast tag matches a live source of a valid entry.
    function automatic rs_entry_t wake_entry(rs_entry_t e, logic wk_valid,
                                             logic [PHY_RF_ADDR_WIDTH-1:0] wk_tag);
        rs_entry_t r;
        r = e;
        if (wk_valid && e.valid) begin
            if (e.uop.rs1_valid && (e.uop.rs1 == wk_tag)) r.rs1_rdy = 1'b1;
            if (e.uop.rs2_valid && (e.uop.rs2 == wk_tag)) r.rs2_rdy = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/qu_rs_int_select.sv
// Oldest-eligible picker: lowest set bit of the eligible vector wins.
module qu_rs_select #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]         eligible,
    output logic [NUM_ENTRIES-1:0]         grant,
    output logic [$clog2(NUM_ENTRIES)-1:0] idx,
    output logic                           any
);

    localparam int unsigned IW = $clog2(NUM_ENTRIES);

    // Scan from the top down so the lowest eligible index is the last one written.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qu_rs_int.sv
// Integer/control reservation station: compacting age-ordered queue with
// tag wakeup and a registered valid/ready issue stage.
module qu_rs_int
    import qu_uop_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [UOP_WIDTH-1:0]         in_uop,
    input  logic                         in_rs1_ready,
    input  logic                         in_rs2_ready,
    input  logic                         wakeup_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] wakeup_tag,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [UOP_WIDTH-1:0]         out_uop
);

    localparam int unsigned IW = $clog2(NUM_ENTRIES);
    localparam int unsigned CW = IW + 1;

    rs_entry_t              entries_q [NUM_ENTRIES];
    rs_entry_t              shifted   [NUM_ENTRIES];
    rs_entry_t              entries_d [NUM_ENTRIES];
    rs_entry_t              new_entry;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [IW-1:0]          wr_idx;
    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] grant;
    logic [IW-1:0]          sel_idx;
    logic                   sel_any;
    logic                   issue;
    logic                   dispatch;
    logic [UOP_WIDTH-1:0]   issue_uop;
    logic                   out_valid_q;
    logic [UOP_WIDTH-1:0]   out_uop_q;
    uop_t                   dis_uop;

    assign dis_uop   = uop_t'(in_uop);
    assign in_ready  = (count_q != CW'(NUM_ENTRIES));
    assign dispatch  = in_valid && in_ready;
    assign issue     = sel_any && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_uop   = out_uop_q;

    // Eligibility uses registered ready bits only, so a wakeup takes one cycle to count.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            eligible[i] = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
        end
    end

    qu_rs_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_select (
        .eligible (eligible),
        .grant    (grant),
        .idx      (sel_idx),
        .any      (sel_any)
    );

    // One-hot mux of the granted uop.
    always_comb begin
        issue_uop = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) issue_uop = issue_uop | entries_q[i].uop;
        end
    end

    // Close the gap left by the issuing slot: everything above it moves down one.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue && (i >= int'(sel_idx))) begin
                if (i == NUM_ENTRIES - 1) shifted[i] = rs_entry_t'('0);
                else                      shifted[i] = entries_q[(i + 1) % NUM_ENTRIES];
            end else begin
                shifted[i] = entries_q[i];
            end
        end
    end

    // Apply wakeup to stored and incoming entries, then append the dispatch at the tail.
    always_comb begin
        new_entry         = rs_entry_t'('0);
        new_entry.uop     = dis_uop;
        new_entry.valid   = 1'b1;
        new_entry.rs1_rdy = !dis_uop.rs1_valid || in_rs1_ready;
        new_entry.rs2_rdy = !dis_uop.rs2_valid || in_rs2_ready;
        new_entry         = wake_entry(new_entry, wakeup_valid, wakeup_tag);
        wr_idx            = IW'(count_q - CW'(issue));
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_d[i] = wake_entry(shifted[i], wakeup_valid, wakeup_tag);
        end
        if (dispatch) entries_d[wr_idx] = new_entry;
        count_d = count_q - CW'(issue) + CW'(dispatch);
    end

    // Station state and output register; flush wins over everything in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_uop_q   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= rs_entry_t'('0);
        end else if (flush) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= rs_entry_t'('0);
        end else begin
            count_q <= count_d;
            for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= entries_d[i];
            if (issue) begin
                out_valid_q <= 1'b1;
                out_uop_q   <= issue_uop;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
